// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Write-side front end of the register file. Collects writeback requests from
// the single-cycle ALU (source 0) and the multi-cycle FPU/load path (source 1).
// Requests go into a small in-order queue, which drains one write per cycle
// onto the register file write port (A3/WD3/WE3).
//
// Optional feature, compile-time macro WB_BYPASS_EN:
//   defined   - pending-write lookup (lk_hit*/lk_fwd*) reports queued data to
//               decode so it can forward values not yet committed.
//   undefined - no lookup comparators; lk_hit*/lk_fwd* are tied to 0 and the
//               lk_A* inputs are ignored.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   s0_valid/ready/rd/data  ALU writeback request (older of the two sources)
//   s1_valid/ready/rd/data  FPU/load writeback request
//   hold                    blocks draining this cycle
//   rf_A3/rf_WD3/rf_WE3     register file write port (head of queue)
//   lk_A1/lk_A2             lookup indices from decode read ports
//   lk_hit1/lk_hit2         a queued write to lk_AN exists
//   lk_fwd1/lk_fwd2         data of the youngest queued write to lk_AN
//   count/full/empty        occupancy
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       s0_valid,
  output logic                       s0_ready,
  input  logic [ADDR_W-1:0]          s0_rd,
  input  logic [DATA_W-1:0]          s0_data,
  input  logic                       s1_valid,
  output logic                       s1_ready,
  input  logic [ADDR_W-1:0]          s1_rd,
  input  logic [DATA_W-1:0]          s1_data,
  input  logic                       hold,
  output logic [ADDR_W-1:0]          rf_A3,
  output logic [DATA_W-1:0]          rf_WD3,
  output logic                       rf_WE3,
  input  logic [ADDR_W-1:0]          lk_A1,
  input  logic [ADDR_W-1:0]          lk_A2,
  output logic                       lk_hit1,
  output logic                       lk_hit2,
  output logic [DATA_W-1:0]          lk_fwd1,
  output logic [DATA_W-1:0]          lk_fwd2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Ready thresholds: s0 needs one free slot, s1 needs two so that a
  // simultaneous s0 accept can never leave it without room.
  localparam logic [CNT_W-1:0] S0_LIMIT  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] S1_LIMIT  = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  entry_vld_q, entry_vld_d;
  logic [ADDR_W-1:0] entry_rd_q   [DEPTH];
  logic [ADDR_W-1:0] entry_rd_d   [DEPTH];
  logic [DATA_W-1:0] entry_data_q [DEPTH];
  logic [DATA_W-1:0] entry_data_d [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake, x0 filter and drain
  // ---------------------------------------------------------------------------
  logic             s0_acc, s1_acc;
  logic             s0_enq, s1_enq;
  logic             drain;
  logic [PTR_W-1:0] s1_slot;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_DEPTH);
  assign count    = count_q;

  // Readiness looks only at the registered count; a drain in the same cycle
  // does not open extra room.
  assign s0_ready = (count_q <= S0_LIMIT);
  assign s1_ready = (count_q <= S1_LIMIT);

  assign s0_acc   = s0_valid && s0_ready;
  assign s1_acc   = s1_valid && s1_ready;

  // Writes to x0 complete the handshake but are dropped: they would never
  // change architectural state.
  assign s0_enq   = s0_acc && (s0_rd != '0);
  assign s1_enq   = s1_acc && (s1_rd != '0);

  // s0 is older, so it takes the tail slot and s1 lands directly behind it.
  assign s1_slot  = tail_q + PTR_W'(s0_enq);

  assign drain    = !empty && !hold;

  assign rf_WE3   = drain;
  assign rf_A3    = empty ? '0 : entry_rd_q[head_q];
  assign rf_WD3   = empty ? '0 : entry_data_q[head_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets its hold value first, so no path
  // leaves it unassigned and no latch is inferred; blocking '=' is correct
  // inside always_comb.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    entry_vld_d  = entry_vld_q;
    entry_rd_d   = entry_rd_q;
    entry_data_d = entry_data_q;

    if (drain) begin
      entry_vld_d[head_q] = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end

    // Acceptance never exceeds the free slots counted before the drain, so
    // the enqueue slots can never coincide with the head being popped.
    if (s0_enq) begin
      entry_vld_d[tail_q]  = 1'b1;
      entry_rd_d[tail_q]   = s0_rd;
      entry_data_d[tail_q] = s0_data;
    end

    if (s1_enq) begin
      entry_vld_d[s1_slot]  = 1'b1;
      entry_rd_d[s1_slot]   = s1_rd;
      entry_data_d[s1_slot] = s1_data;
    end

    tail_d  = tail_q + PTR_W'(s0_enq) + PTR_W'(s1_enq);
    count_d = count_q + CNT_W'(s0_enq) + CNT_W'(s1_enq) - CNT_W'(drain);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      entry_vld_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      entry_vld_q <= entry_vld_d;
    end
  end

  // NOTE: the payload storage is deliberately not reset. Nothing reads it
  // unless the matching valid bit is set (or the queue is non-empty), and
  // leaving it reset-free lets it map onto plain storage cells.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd_q[i]   <= entry_rd_d[i];
      entry_data_q[i] <= entry_data_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write lookup
  // ---------------------------------------------------------------------------
`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] lk_idx;

  // Walk from head (oldest) to tail (youngest); a later match overwrites an
  // earlier one, so the youngest pending value wins. Only registered entries
  // are searched, so this cycle's accepts are invisible until the edge, while
  // the head being drained this cycle is still reported.
  always_comb begin
    lk_hit1 = 1'b0;
    lk_hit2 = 1'b0;
    lk_fwd1 = '0;
    lk_fwd2 = '0;
    lk_idx  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if (entry_vld_q[lk_idx] && (lk_A1 != '0) && (entry_rd_q[lk_idx] == lk_A1)) begin
        lk_hit1 = 1'b1;
        lk_fwd1 = entry_data_q[lk_idx];
      end
      if (entry_vld_q[lk_idx] && (lk_A2 != '0) && (entry_rd_q[lk_idx] == lk_A2)) begin
        lk_hit2 = 1'b1;
        lk_fwd2 = entry_data_q[lk_idx];
      end
    end
  end
`else
  // Lookup not built: outputs tied off, indices intentionally ignored.
  logic unused_lk;
  assign unused_lk = ^{lk_A1, lk_A2};

  assign lk_hit1 = 1'b0;
  assign lk_hit2 = 1'b0;
  assign lk_fwd1 = '0;
  assign lk_fwd2 = '0;
`endif

endmodule
